// File: rtl/qq_op_ctrl.sv
// QuickQ operation controller: sequences each enqueue/dequeue through the heap engine and the
// last-pointer counter stage; >=5 cycles per legal op; req_ready only in IDLE, host holds request.
module qq_op_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              deq_valid,
  output logic [DATA_W-1:0] deq_data,
  output logic              err,
  output logic              eng_start,
  output logic              eng_op,
  output logic [DATA_W-1:0] eng_data,
  output logic [31:0]       eng_last,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_rdata,
  output logic [31:0]       last_addr,
  output logic              enq,
  output logic              deq,
  output logic              last_done,
  input  logic [31:0]       new_last,
  output logic              full,
  output logic              empty,
  output logic              sync_err
);

  typedef enum logic [2:0] {IDLE, START, WAIT, COMMIT, SYNC} state_t;

  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state, state_nxt;
  logic [7:0]  tcnt;
  logic        illegal;
  logic        timeout;
  logic [31:0] exp_last;

  assign full     = (last_addr == DEPTH_W);
  assign empty    = (last_addr == 32'd0);
  assign illegal  = req_op ? empty : full;
  assign timeout  = (tcnt == TO_LAST);
  assign exp_last = eng_op ? (last_addr - 32'd1) : (last_addr + 32'd1);

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    eng_start = 1'b0;
    last_done = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    deq_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !illegal) state_nxt = START;
      end
      START: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done)     state_nxt = COMMIT;
        else if (timeout) state_nxt = IDLE;
      end
      COMMIT: begin
        last_done = 1'b1;
        enq       = ~eng_op;
        deq       = eng_op;
        deq_valid = eng_op;
        state_nxt = SYNC;
      end
      SYNC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= 8'd0;
      err       <= 1'b0;
      deq_data  <= '0;
      eng_op    <= 1'b0;
      eng_data  <= '0;
      eng_last  <= 32'd0;
      last_addr <= 32'd0;
      sync_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              eng_op   <= req_op;
              eng_data <= req_data;
            end
          end
        end
        START: tcnt <= 8'd0;
        WAIT: begin
          tcnt <= tcnt + 8'd1;
          if (eng_done)     deq_data <= eng_rdata;
          else if (timeout) err      <= 1'b1;
        end
        SYNC: begin
          // A mismatching pointer is still adopted: the counter stage owns the RAM-side view.
          last_addr <= new_last;
          eng_last  <= new_last;
          if (new_last != exp_last) sync_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qq_op_ctrl.sv
// Directed bench for qq_op_ctrl with DEPTH=4, TIMEOUT=8 and a behavioural counter stage.
module tb_qq_op_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_op;
  logic [31:0] req_data;
  logic        req_ready, deq_valid, err, eng_start, eng_op;
  logic [31:0] deq_data, eng_data, eng_last;
  logic        eng_done;
  logic [31:0] eng_rdata;
  logic [31:0] last_addr, new_last;
  logic        enq, deq, last_done, full, empty, sync_err;
  logic        corrupt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qq_op_ctrl #(.DEPTH(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .err(err),
    .eng_start(eng_start), .eng_op(eng_op), .eng_data(eng_data), .eng_last(eng_last),
    .eng_done(eng_done), .eng_rdata(eng_rdata),
    .last_addr(last_addr), .enq(enq), .deq(deq), .last_done(last_done), .new_last(new_last),
    .full(full), .empty(empty), .sync_err(sync_err)
  );

  // Counter stage: registers the updated pointer on last_done; corrupt adds an extra step.
  always @(posedge clk) begin
    if (rst)            new_last <= 32'd0;
    else if (last_done) new_last <= deq ? (last_addr - 32'd1)
                                        : (last_addr + 32'd1 + {31'd0, corrupt});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // One legal operation; eng_done comes dly cycles after eng_start. Called at a negedge in IDLE.
  task automatic run_op(input logic op, input logic [31:0] data, input logic [31:0] rdata,
                        input int dly, input logic [31:0] exp_last);
    req_valid = 1'b1; req_op = op; req_data = data;
    @(negedge clk);
    req_valid = 1'b0;
    chk("op_start", {31'd0, eng_start}, 32'd1);
    chk("op_ready_busy", {31'd0, req_ready}, 32'd0);
    chk("op_eng_data", eng_data, data);
    chk("op_eng_op", {31'd0, eng_op}, {31'd0, op});
    repeat (dly) @(negedge clk);
    eng_done = 1'b1; eng_rdata = rdata;
    @(negedge clk);
    eng_done = 1'b0; eng_rdata = 32'hdead_beef;
    chk("commit_last_done", {31'd0, last_done}, 32'd1);
    chk("commit_enq", {31'd0, enq}, {31'd0, ~op});
    chk("commit_deq", {31'd0, deq}, {31'd0, op});
    chk("commit_deq_valid", {31'd0, deq_valid}, {31'd0, op});
    if (op) chk("commit_deq_data", deq_data, rdata);
    @(negedge clk);
    chk("sync_last_done", {31'd0, last_done}, 32'd0);
    @(negedge clk);
    chk("idle_last_addr", last_addr, exp_last);
    chk("idle_eng_last", eng_last, exp_last);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_data = 32'd0;
    eng_done = 1'b0; eng_rdata = 32'd0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_last_addr", last_addr, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_strobes", {26'd0, eng_start, enq, deq, last_done, deq_valid, err}, 32'd0);
    chk("rst_regs", deq_data | eng_data | eng_last | {31'd0, eng_op}, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err}, 32'd0);

    // Dequeue on empty queue is rejected
    req_valid = 1'b1; req_op = 1'b1; req_data = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    chk("deq_empty_err", {31'd0, err}, 32'd1);
    chk("deq_empty_nostart", {31'd0, eng_start}, 32'd0);
    @(negedge clk);
    chk("deq_empty_err_clr", {31'd0, err}, 32'd0);
    chk("deq_empty_start2", {31'd0, eng_start}, 32'd0);
    chk("deq_empty_addr", last_addr, 32'd0);
    chk("deq_empty_empty", {31'd0, empty}, 32'd1);

    // Fill to DEPTH
    run_op(1'b0, 32'h10, 32'h0, 2, 32'd1);
    chk("enq1_empty", {31'd0, empty}, 32'd0);
    run_op(1'b0, 32'h20, 32'h0, 2, 32'd2);
    run_op(1'b0, 32'h30, 32'h0, 2, 32'd3);
    chk("enq3_sync_err", {31'd0, sync_err}, 32'd0);
    chk("enq3_full", {31'd0, full}, 32'd0);
    run_op(1'b0, 32'h40, 32'h0, 1, 32'd4);
    chk("enq4_full", {31'd0, full}, 32'd1);

    // Enqueue while full is rejected
    req_valid = 1'b1; req_op = 1'b0; req_data = 32'h50;
    @(negedge clk);
    req_valid = 1'b0;
    chk("enq_full_err", {31'd0, err}, 32'd1);
    chk("enq_full_nostart", {31'd0, eng_start}, 32'd0);
    @(negedge clk);
    chk("enq_full_addr", last_addr, 32'd4);
    chk("enq_full_full", {31'd0, full}, 32'd1);

    // Dequeue returns engine result
    run_op(1'b1, 32'h0, 32'h10, 3, 32'd3);

    // Engine timeout: 8 WAIT cycles, then err in the following IDLE cycle
    req_valid = 1'b1; req_op = 1'b0; req_data = 32'h60;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_start", {31'd0, eng_start}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_wait_quiet", {30'd0, err, last_done}, 32'd0);
      chk("to_wait_busy", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_idle", {31'd0, req_ready}, 32'd1);
    chk("to_no_commit", {31'd0, last_done}, 32'd0);
    @(negedge clk);
    chk("to_err_clr", {31'd0, err}, 32'd0);
    chk("to_addr", last_addr, 32'd3);

    // Reset while in WAIT, then a late eng_done
    req_valid = 1'b1; req_op = 1'b1; req_data = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eng_done = 1'b1; eng_rdata = 32'h77;
    chk("abort_addr", last_addr, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    eng_done = 1'b0;
    chk("abort_quiet", {26'd0, eng_start, enq, deq, last_done, deq_valid, err}, 32'd0);
    @(negedge clk);
    chk("abort_quiet2", {26'd0, eng_start, enq, deq, last_done, deq_valid, err}, 32'd0);
    chk("abort_deq_data", deq_data, 32'd0);

    // Counter stage returns last_addr+2: sticky sync_err, pointer adopted
    corrupt = 1'b1;
    run_op(1'b0, 32'h90, 32'h0, 2, 32'd2);
    corrupt = 1'b0;
    chk("sync_err_set", {31'd0, sync_err}, 32'd1);
    run_op(1'b1, 32'h0, 32'h90, 2, 32'd1);
    chk("sync_err_sticky", {31'd0, sync_err}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
